alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time onto an external datapath.
// MULTU is held on the datapath for a fixed number of cycles.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [5:0]       dp_signal,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  input  logic [31:0]      dp_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [5:0] opAnd   = 6'd36;
  localparam logic [5:0] opOr    = 6'd37;
  localparam logic [5:0] opAdd   = 6'd32;
  localparam logic [5:0] opSub   = 6'd34;
  localparam logic [5:0] opSlt   = 6'd42;
  localparam logic [5:0] opSrl   = 6'd2;
  localparam logic [5:0] opMultu = 6'd25;
  localparam logic [5:0] opMfhi  = 6'd16;
  localparam logic [5:0] opMflo  = 6'd18;

  localparam int unsigned mulCntW = $clog2(MUL_CYCLES + 1);
  localparam logic [mulCntW-1:0] mulLast = mulCntW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MUL,
    RESP
  } stateT;

  stateT state, stateNext;

  logic [mulCntW-1:0] mulCnt;
  logic [5:0]         opReg;
  logic               reqLegal;
  logic               handshake;

  always_comb begin
    reqLegal = 1'b0;
    case (req_op)
      opAnd, opOr, opAdd, opSub, opSlt, opSrl, opMultu, opMfhi, opMflo: reqLegal = 1'b1;
      default: reqLegal = 1'b0;
    endcase
  end

  assign handshake = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    dp_signal = '0;
    case (state)
      ISSUE:   dp_signal = opReg;
      MUL:     dp_signal = opMultu;
      default: dp_signal = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (!reqLegal)              stateNext = RESP;
          else if (req_op == opMultu) stateNext = MUL;
          else                        stateNext = ISSUE;
        end
      end
      ISSUE:   stateNext = RESP;
      MUL:     if (mulCnt == mulLast) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulCnt   <= '0;
      opReg    <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            opReg  <= req_op;
            dp_a   <= req_a;
            dp_b   <= req_b;
            mulCnt <= '0;
            // Illegal ops skip the datapath, so the response is settled here
            if (!reqLegal) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          rsp_data <= dp_out;
          rsp_err  <= 1'b0;
        end
        MUL: begin
          mulCnt <= mulCnt + 1'b1;
          if (mulCnt == mulLast) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) op_count <= op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small datapath stub.
// A second instance (CNT_W=2) exercises counter wrap and back-to-back issue.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reqValid, reqReady, rspValid, rspReady, rspErr, busy;
  logic [5:0]  reqOp, dpSignal;
  logic [31:0] reqA, reqB, dpA, dpB, dpOut, rspData;
  logic [15:0] opCount;

  logic        reset2, reqValid2, reqReady2, rspValid2, rspReady2, rspErr2, busy2;
  logic [5:0]  reqOp2, dpSignal2;
  logic [31:0] reqA2, reqB2, dpA2, dpB2, dpOut2, rspData2;
  logic [1:0]  opCount2;

  alu_op_sequencer #(.MUL_CYCLES(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
    .req_op(reqOp), .req_a(reqA), .req_b(reqB), .dp_signal(dpSignal),
    .dp_a(dpA), .dp_b(dpB), .dp_out(dpOut), .rsp_valid(rspValid),
    .rsp_ready(rspReady), .rsp_data(rspData), .rsp_err(rspErr),
    .busy(busy), .op_count(opCount)
  );

  alu_op_sequencer #(.MUL_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .req_valid(reqValid2), .req_ready(reqReady2),
    .req_op(reqOp2), .req_a(reqA2), .req_b(reqB2), .dp_signal(dpSignal2),
    .dp_a(dpA2), .dp_b(dpB2), .dp_out(dpOut2), .rsp_valid(rspValid2),
    .rsp_ready(rspReady2), .rsp_data(rspData2), .rsp_err(rspErr2),
    .busy(busy2), .op_count(opCount2)
  );

  // Datapath stub: combinational ALU plus HI/LO written while MULTU is driven
  logic [31:0] hiReg = '0, loReg = '0;
  always @(posedge clk) if (dpSignal == 6'd25) {hiReg, loReg} <= 64'(dpA) * 64'(dpB);
  always_comb begin
    dpOut = '0;
    case (dpSignal)
      6'd36:   dpOut = dpA & dpB;
      6'd37:   dpOut = dpA | dpB;
      6'd32:   dpOut = dpA + dpB;
      6'd34:   dpOut = dpA - dpB;
      6'd42:   dpOut = ($signed(dpA) < $signed(dpB)) ? 32'd1 : 32'd0;
      6'd2:    dpOut = dpA >> dpB[4:0];
      6'd16:   dpOut = hiReg;
      6'd18:   dpOut = loReg;
      default: dpOut = '0;
    endcase
  end
  assign dpOut2 = (dpSignal2 == 6'd32) ? dpA2 + dpB2 : '0;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          lat, dpCycles;
  logic [5:0]  sigSeen;
  logic [31:0] rData;
  logic        rErr;

  // Issues one op; lat counts rising edges from the handshake edge (inclusive)
  // to the first sample where rsp_valid is high.
  task automatic doOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int stall);
    @(negedge clk);
    reqValid = 1'b1; reqOp = op; reqA = a; reqB = b; rspReady = (stall == 0);
    @(posedge clk); #1;
    reqValid = 1'b0; reqOp = '0; reqA = '1; reqB = '1;
    lat = 1; dpCycles = 0; sigSeen = '0;
    while (!rspValid && lat < 200) begin
      if (dpSignal != 0) begin
        dpCycles++;
        sigSeen = dpSignal;
      end
      @(posedge clk); #1;
      lat++;
    end
    rData = rspData;
    rErr  = rspErr;
    if (stall > 0) begin
      @(negedge clk);
      reqValid = 1'b1; reqOp = 6'd36;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        checkVal("stallValid", 32'(rspValid), 1);
        checkVal("stallData", rspData, rData);
        checkVal("stallReqReady", 32'(reqReady), 0);
        checkVal("stallDpSignal", 32'(dpSignal), 0);
      end
      @(negedge clk);
      reqValid = 1'b0;
      rspReady = 1'b1;
    end
    @(posedge clk); #1;
    checkVal("rspDrop", 32'(rspValid), 0);
    checkVal("readyAgain", 32'(reqReady), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sawValid;
    int found, cyc, lastCyc;
    logic [1:0] prevCnt;
    int expSeq[5] = '{1, 2, 3, 0, 1};

    reset = 1'b1; reqValid = 1'b0; rspReady = 1'b0; reqOp = '0; reqA = '0; reqB = '0;
    reset2 = 1'b1; reqValid2 = 1'b0; rspReady2 = 1'b0; reqOp2 = 6'd32; reqA2 = 32'd1; reqB2 = 32'd2;
    #12;
    checkVal("rstDpSignal", 32'(dpSignal), 0);
    checkVal("rstDpA", dpA, 0);
    checkVal("rstRspValid", 32'(rspValid), 0);
    checkVal("rstRspData", rspData, 0);
    checkVal("rstBusy", 32'(busy), 0);
    checkVal("rstOpCount", 32'(opCount), 0);
    @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
    checkVal("readyAfterReset", 32'(reqReady), 1);

    // Reset ten cycles into a MULTU
    @(negedge clk);
    reqValid = 1'b1; reqOp = 6'd25; reqA = 32'd3; reqB = 32'd4; rspReady = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checkVal("midMulBusy", 32'(busy), 1);
    checkVal("midMulSignal", 32'(dpSignal), 25);
    #2 reset = 1'b1;
    #1;
    checkVal("abortDpSignal", 32'(dpSignal), 0);
    checkVal("abortDpA", dpA, 0);
    checkVal("abortDpB", dpB, 0);
    checkVal("abortBusy", 32'(busy), 0);
    checkVal("abortRspValid", 32'(rspValid), 0);
    checkVal("abortRspErr", 32'(rspErr), 0);
    checkVal("abortOpCount", 32'(opCount), 0);
    @(negedge clk);
    reset = 1'b0;
    checkVal("abortReady", 32'(reqReady), 1);
    sawValid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rspValid) sawValid++;
    end
    checkVal("abortNoRsp", 32'(sawValid), 0);
    checkVal("abortOpCountHold", 32'(opCount), 0);

    // ADD 5 + 7
    doOp(6'd32, 32'd5, 32'd7, 0);
    checkVal("addLat", 32'(lat), 2);
    checkVal("addDpCycles", 32'(dpCycles), 1);
    checkVal("addSignal", 32'(sigSeen), 32);
    checkVal("addData", rData, 12);
    checkVal("addErr", 32'(rErr), 0);
    checkVal("addOpCount", 32'(opCount), 1);
    checkVal("addDpAHeld", dpA, 5);
    checkVal("addDpBHeld", dpB, 7);

    // MULTU 3 * 4 then MFLO
    doOp(6'd25, 32'd3, 32'd4, 0);
    checkVal("mulLat", 32'(lat), 33);
    checkVal("mulDpCycles", 32'(dpCycles), 32);
    checkVal("mulSignal", 32'(sigSeen), 25);
    checkVal("mulData", rData, 0);
    checkVal("mulErr", 32'(rErr), 0);
    checkVal("mulOpCount", 32'(opCount), 2);
    doOp(6'd18, 32'd0, 32'd0, 0);
    checkVal("mfloLat", 32'(lat), 2);
    checkVal("mfloData", rData, 12);
    checkVal("mfloOpCount", 32'(opCount), 3);

    // Illegal opcode 63
    doOp(6'd63, 32'd9, 32'd9, 0);
    checkVal("illLat", 32'(lat), 1);
    checkVal("illDpCycles", 32'(dpCycles), 0);
    checkVal("illData", rData, 0);
    checkVal("illErr", 32'(rErr), 1);
    checkVal("illOpCount", 32'(opCount), 4);

    // SUB 1 - 2 with rsp_ready held low for 5 cycles
    doOp(6'd34, 32'd1, 32'd2, 5);
    checkVal("subLat", 32'(lat), 2);
    checkVal("subData", rData, 32'hFFFF_FFFF);
    checkVal("subErr", 32'(rErr), 0);
    checkVal("subOpCount", 32'(opCount), 5);
    checkVal("subIdleBusy", 32'(busy), 0);

    doOp(6'd36, 32'h0000_F0F0, 32'h0000_FF00, 0);
    checkVal("andData", rData, 32'h0000_F000);
    doOp(6'd42, 32'hFFFF_FFFF, 32'd1, 0);
    checkVal("sltData", rData, 1);
    checkVal("sltOpCount", 32'(opCount), 7);

    // Second instance: back-to-back ADDs with a 2-bit counter
    @(negedge clk);
    reqValid2 = 1'b1; rspReady2 = 1'b1;
    prevCnt = opCount2; found = 0; cyc = 0; lastCyc = 0;
    while (found < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (opCount2 != prevCnt) begin
        checkVal("wrapCnt", 32'(opCount2), 32'(expSeq[found]));
        if (found > 0) checkVal("b2bGap", 32'(cyc - lastCyc), 3);
        lastCyc = cyc;
        prevCnt = opCount2;
        found++;
      end
    end
    checkVal("wrapDone", 32'(found), 5);
    reqValid2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
